// File: rtl/bnn_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pkg
// Shared definitions for the BNN digit classifier:
//   - top-level sequencer state encodings (driven by the sequencer, decoded by
//     each layer to know when it owns the datapath)
//   - layer geometry constants
//   - layer-three control FSM states
// -----------------------------------------------------------------------------
package bnn_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_LOAD    = 3'b001,
        S_LAYER_1 = 3'b010,
        S_LAYER_2 = 3'b011,
        S_LAYER_3 = 3'b100
    } seq_state_e;

    localparam int unsigned L2_OUT_BITS = 196;
    localparam int unsigned N_CLASSES   = 10;

    typedef enum logic [1:0] {
        L3_IDLE,
        L3_ACCUM,
        L3_COMPARE,
        L3_FINISH
    } l3_state_e;

endpackage

// File: rtl/bnn_popcount.sv
// -----------------------------------------------------------------------------
// bnn_popcount
// Purely combinational population count of a WIDTH-bit vector.
// Ports:
//   bits_i   [WIDTH-1:0]             input vector
//   count_o  [$clog2(WIDTH+1)-1:0]   number of set bits in bits_i
// -----------------------------------------------------------------------------
module bnn_popcount #(
    parameter int unsigned WIDTH = 28
) (
    input  logic [WIDTH-1:0]             bits_i,
    output logic [$clog2(WIDTH+1)-1:0]   count_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    always_comb begin
        count_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            count_o = count_o + CW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/layer_three.sv
// -----------------------------------------------------------------------------
// layer_three
// Final dense BNN stage: XNOR-popcount of the feature vector against each
// class weight row (CHUNK bits per cycle), followed by a running argmax.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   state      sequencer state; this block runs while state == S_LAYER_3
//   features   binarised feature vector (held stable upstream)
//   weights    class c row at weights[c*N_FEAT +: N_FEAT] (static)
//   digit      winning class index (ties resolve to the lower index)
//   max_score  popcount score of the winning class
//   done       result valid; cleared when the sequencer leaves S_LAYER_3
// -----------------------------------------------------------------------------
module layer_three
    import bnn_pkg::*;
#(
    parameter int unsigned N_FEAT    = L2_OUT_BITS,
    parameter int unsigned N_CLASSES = bnn_pkg::N_CLASSES,
    parameter int unsigned CHUNK     = 28
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [2:0]                        state,
    input  logic [N_FEAT-1:0]                 features,
    input  logic [N_CLASSES*N_FEAT-1:0]       weights,
    output logic [$clog2(N_CLASSES)-1:0]      digit,
    output logic [$clog2(N_FEAT+1)-1:0]       max_score,
    output logic                              done
);

    localparam int unsigned NCHUNK     = N_FEAT / CHUNK;
    localparam int unsigned CLS_W      = $clog2(N_CLASSES);
    localparam int unsigned CHK_W      = $clog2(NCHUNK);
    localparam int unsigned ACC_W      = $clog2(N_FEAT + 1);
    localparam int unsigned PC_W       = $clog2(CHUNK + 1);
    localparam int unsigned FEAT_IDX_W = $clog2(N_FEAT);
    localparam int unsigned W_IDX_W    = $clog2(N_CLASSES * N_FEAT);

    if (N_FEAT % CHUNK != 0) begin : g_chunk_check
        $error("CHUNK must divide N_FEAT exactly");
    end

    l3_state_e          fsm_q, fsm_d;
    logic [CLS_W-1:0]   class_idx_q, class_idx_d;
    logic [CHK_W-1:0]   chunk_idx_q, chunk_idx_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   best_score_q, best_score_d;
    logic [CLS_W-1:0]   best_idx_q, best_idx_d;
    logic [CLS_W-1:0]   digit_q, digit_d;
    logic [ACC_W-1:0]   max_score_q, max_score_d;
    logic               done_q, done_d;

    logic                   run;
    logic [FEAT_IDX_W-1:0]  f_off;
    logic [W_IDX_W-1:0]     w_off;
    logic [CHUNK-1:0]       xnor_bits;
    logic [PC_W-1:0]        pop;
    logic                   win;

    assign run = (state == S_LAYER_3);

    always_comb begin
        f_off     = FEAT_IDX_W'(chunk_idx_q) * FEAT_IDX_W'(CHUNK);
        w_off     = W_IDX_W'(class_idx_q) * W_IDX_W'(N_FEAT) + W_IDX_W'(f_off);
        xnor_bits = ~(features[f_off +: CHUNK] ^ weights[w_off +: CHUNK]);
    end

    bnn_popcount #(
        .WIDTH (CHUNK)
    ) u_popcount (
        .bits_i  (xnor_bits),
        .count_o (pop)
    );

    // Class 0 always seeds the running best; afterwards only a strictly
    // greater score replaces it, so ties keep the lower index.
    assign win = (class_idx_q == '0) || (acc_q > best_score_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q        <= L3_IDLE;
            class_idx_q  <= '0;
            chunk_idx_q  <= '0;
            acc_q        <= '0;
            best_score_q <= '0;
            best_idx_q   <= '0;
            digit_q      <= '0;
            max_score_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            class_idx_q  <= class_idx_d;
            chunk_idx_q  <= chunk_idx_d;
            acc_q        <= acc_d;
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
            digit_q      <= digit_d;
            max_score_q  <= max_score_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        fsm_d        = fsm_q;
        class_idx_d  = class_idx_q;
        chunk_idx_d  = chunk_idx_q;
        acc_d        = acc_q;
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        digit_d      = digit_q;
        max_score_d  = max_score_q;
        done_d       = done_q;

        case (fsm_q)
            L3_IDLE: begin
                if (run) begin
                    acc_d        = '0;
                    class_idx_d  = '0;
                    chunk_idx_d  = '0;
                    best_score_d = '0;
                    best_idx_d   = '0;
                    fsm_d        = L3_ACCUM;
                end
            end

            L3_ACCUM: begin
                if (!run) begin
                    fsm_d = L3_IDLE;
                end else begin
                    acc_d = acc_q + ACC_W'(pop);
                    if (chunk_idx_q == CHK_W'(NCHUNK - 1)) begin
                        chunk_idx_d = '0;
                        fsm_d       = L3_COMPARE;
                    end else begin
                        chunk_idx_d = chunk_idx_q + 1'b1;
                    end
                end
            end

            L3_COMPARE: begin
                if (!run) begin
                    fsm_d = L3_IDLE;
                end else begin
                    if (win) begin
                        best_score_d = acc_q;
                        best_idx_d   = class_idx_q;
                    end
                    acc_d = '0;
                    if (class_idx_q == CLS_W'(N_CLASSES - 1)) begin
                        // Publish on the last compare edge so the final
                        // class's result is included without an extra cycle.
                        digit_d     = win ? class_idx_q : best_idx_q;
                        max_score_d = win ? acc_q : best_score_q;
                        done_d      = 1'b1;
                        fsm_d       = L3_FINISH;
                    end else begin
                        class_idx_d = class_idx_q + 1'b1;
                        fsm_d       = L3_ACCUM;
                    end
                end
            end

            L3_FINISH: begin
                if (!run) begin
                    done_d = 1'b0;
                    fsm_d  = L3_IDLE;
                end
            end

            default: fsm_d = L3_IDLE;
        endcase
    end

    assign digit     = digit_q;
    assign max_score = max_score_q;
    assign done      = done_q;

endmodule

// File: tb/tb_layer_three.sv
module tb_layer_three;

    localparam int N_FEAT    = 196;
    localparam int N_CLASSES = 10;
    localparam int LATENCY   = 81;

    logic                          clk;
    logic                          rst;
    logic [2:0]                    state;
    logic [N_FEAT-1:0]             features;
    logic [N_CLASSES*N_FEAT-1:0]   weights;
    logic [3:0]                    digit;
    logic [7:0]                    max_score;
    logic                          done;

    layer_three #(
        .N_FEAT    (N_FEAT),
        .N_CLASSES (N_CLASSES),
        .CHUNK     (28)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .state     (state),
        .features  (features),
        .weights   (weights),
        .digit     (digit),
        .max_score (max_score),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic [7:0] s;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic done_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every rising done pops one expectation.
    always @(negedge clk) begin
        if (done && !done_seen) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("digit", 32'(digit), 32'(e.d));
                check("max_score", 32'(max_score), 32'(e.s));
            end
        end
        done_seen <= done;
    end

    function automatic logic [N_FEAT-1:0] ones_row(input int n);
        logic [N_FEAT-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = 1'b1;
        return r;
    endfunction

    logic [N_FEAT-1:0] rnd;

    task automatic wait_done(input int exp_lat);
        int cnt;
        cnt = 0;
        while (!done && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("latency", 32'(cnt), 32'(exp_lat));
        if (!done && exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic run_case(input logic [3:0] d, input logic [7:0] s, input int hold);
        exp_t e;
        e.d = d;
        e.s = s;
        exp_q.push_back(e);
        state = 3'b100;
        wait_done(LATENCY);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_done", 32'(done), 32'd1);
            check("hold_digit", 32'(digit), 32'(d));
            check("hold_score", 32'(max_score), 32'(s));
        end
    endtask

    task automatic finish_case(input logic [3:0] d, input logic [7:0] s);
        state = 3'b000;
        @(negedge clk);
        check("exit_done", 32'(done), 32'd0);
        check("exit_digit", 32'(digit), 32'(d));
        check("exit_score", 32'(max_score), 32'(s));
    endtask

    task automatic setup_rand7();
        for (int w = 0; w < 7; w++) rnd[w*28 +: 28] = 28'($urandom);
        features = rnd;
        for (int c = 0; c < N_CLASSES; c++)
            weights[c*N_FEAT +: N_FEAT] = (c == 7) ? rnd : ~rnd;
    endtask

    task automatic setup_tie35();
        // features all zero: score = 196 - (ones in row)
        features = '0;
        for (int c = 0; c < N_CLASSES; c++)
            weights[c*N_FEAT +: N_FEAT] = (c == 3 || c == 5) ? ones_row(46) : ones_row(47 + c);
    endtask

    initial begin
        rst      = 1'b1;
        state    = 3'b000;
        features = '0;
        weights  = '0;
        #12;
        @(negedge clk);
        check("reset_done", 32'(done), 32'd0);
        check("reset_digit", 32'(digit), 32'd0);
        check("reset_score", 32'(max_score), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // All zero: every class ties at 196, lowest index wins.
        run_case(4'd0, 8'd196, 0);
        finish_case(4'd0, 8'd196);

        // Class 7 matches exactly; hold for 20 cycles after done.
        setup_rand7();
        run_case(4'd7, 8'd196, 20);
        finish_case(4'd7, 8'd196);

        // Classes 3 and 5 tie at 150.
        setup_tie35();
        run_case(4'd3, 8'd150, 0);
        finish_case(4'd3, 8'd150);

        // Last class wins: features all ones, score = ones in row.
        features = '1;
        for (int c = 0; c < N_CLASSES; c++)
            weights[c*N_FEAT +: N_FEAT] = (c == 9) ? ones_row(180) : ones_row(100 + c);
        run_case(4'd9, 8'd180, 0);
        finish_case(4'd9, 8'd180);

        // Abort at edge 30, then restart from scratch.
        setup_rand7();
        state = 3'b100;
        repeat (29) @(negedge clk);
        state = 3'b000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_done", 32'(done), 32'd0);
            check("abort_digit", 32'(digit), 32'd9);
        end
        run_case(4'd7, 8'd196, 0);
        finish_case(4'd7, 8'd196);

        // Asynchronous reset mid-ACCUM, then a clean run from IDLE.
        setup_tie35();
        state = 3'b100;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_done", 32'(done), 32'd0);
        check("arst_digit", 32'(digit), 32'd0);
        check("arst_score", 32'(max_score), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            exp_t e;
            e.d = 4'd3;
            e.s = 8'd150;
            exp_q.push_back(e);
        end
        wait_done(LATENCY);
        finish_case(4'd3, 8'd150);

        repeat (2) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
